// File: rtl/freq_bcd_display.sv
// Frequency display stage: sequential double-dabble binary->BCD conversion of the
// latched count, followed by an 8-digit multiplexed seven-segment scan.
module freq_bcd_display #(
  parameter int SCAN_DIV = 62500,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [26:0] freq_value,
  input  logic        freq_valid,
  output logic [7:0]  segments,
  output logic [7:0]  segments_bit,
  output logic        busy,
  output logic        overflow
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t        state_q;
  logic [26:0]   bin_q, pend_val_q;
  logic [35:0]   bcd_q, bcd_adj;
  logic [4:0]    cnt_q;
  logic          pend_q, busy_q, ovf_q;
  logic [31:0]   disp_q;

  logic [CW-1:0] scan_q, scan_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d, sel_q;
  logic [3:0]    nib;
  logic          shown, wrap;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 9; i++)
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q || freq_valid) begin
            bin_q   <= pend_q ? pend_val_q : freq_value;
            bcd_q   <= '0;
            cnt_q   <= 5'd27;
            busy_q  <= 1'b1;
            pend_q  <= 1'b0;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q <= {bcd_adj[34:0], bin_q[26]};
          bin_q <= {bin_q[25:0], 1'b0};
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_q <= DONE;
        end
        DONE: begin
          disp_q <= bcd_q[31:0];
          ovf_q  <= |bcd_q[35:32];
          if (pend_q) begin
            bin_q   <= pend_val_q;
            bcd_q   <= '0;
            cnt_q   <= 5'd27;
            pend_q  <= 1'b0;
            state_q <= CONV;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Any pulse that is not started immediately parks here; this overrides the consume above.
      if (freq_valid && (state_q != IDLE || pend_q)) begin
        pend_val_q <= freq_value;
        pend_q     <= 1'b1;
      end
    end
  end

  function automatic logic [7:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: dec7 = 8'b00000011;
      4'd1: dec7 = 8'b10011111;
      4'd2: dec7 = 8'b00100101;
      4'd3: dec7 = 8'b00001101;
      4'd4: dec7 = 8'b10011001;
      4'd5: dec7 = 8'b01001001;
      4'd6: dec7 = 8'b01000001;
      4'd7: dec7 = 8'b00011111;
      4'd8: dec7 = 8'b00000001;
      4'd9: dec7 = 8'b00001001;
      default: dec7 = 8'hFF;
    endcase
  endfunction

  // Select and segment data are both computed from the next index so they flip together.
  always_comb begin
    wrap   = (scan_q == CW'(SCAN_DIV - 1));
    scan_d = wrap ? '0 : scan_q + 1'b1;
    idx_d  = wrap ? idx_q + 3'd1 : idx_q;
    nib    = disp_q[{idx_d, 2'b00} +: 4];
    shown  = !BLANK_LZ || (idx_d == 3'd0) || ((disp_q >> {idx_d, 2'b00}) != 32'd0);
    seg_d  = ovf_q ? 8'b11111101 : (shown ? dec7(nib) : 8'hFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
      seg_q  <= 8'b00000011;
      sel_q  <= 8'b11111110;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      sel_q  <= ~(8'b1 << idx_d);
    end
  end

  assign segments     = seg_q;
  assign segments_bit = sel_q;
  assign busy         = busy_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_freq_bcd_display.sv
// Directed bench for freq_bcd_display: two instances (blanking on/off) with a short scan period.
module tb_freq_bcd_display;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [26:0] freq_value;
  logic        freq_valid;
  logic [7:0]  seg1, sel1, seg0, sel0;
  logic        busy1, ovf1, busy0, ovf0;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  fr1 [8];
  logic [7:0]  fr0 [8];
  logic [7:0]  exp [8];

  freq_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .freq_value(freq_value), .freq_valid(freq_valid),
    .segments(seg1), .segments_bit(sel1), .busy(busy1), .overflow(ovf1));

  freq_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .freq_value(freq_value), .freq_valid(freq_valid),
    .segments(seg0), .segments_bit(sel0), .busy(busy0), .overflow(ovf0));

  always #5 clk = ~clk;

  task automatic convert(input logic [26:0] v, output int bc);
    @(negedge clk);
    freq_value = v;
    freq_valid = 1'b1;
    @(negedge clk);
    freq_valid = 1'b0;
    bc = 0;
    while (busy1 && bc < 100) begin
      bc++;
      @(negedge clk);
    end
  endtask

  task automatic get_frame();
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin fr1[i] = 8'h00; fr0[i] = 8'h00; end
    repeat (36) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        m = ~(8'b1 << i);
        if (sel1 == m) fr1[i] = seg1;
        if (sel0 == m) fr0[i] = seg0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; freq_valid = 1'b0; freq_value = '0;
    #21;
    total++; if (sel1 !== 8'hFE) begin bad++; $display("FAIL reset_sel got=%h exp=fe", sel1); end
    total++; if (seg1 !== 8'h03) begin bad++; $display("FAIL reset_seg got=%h exp=03", seg1); end
    total++; if (busy1 !== 1'b0 || ovf1 !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b ovf=%b exp=0/0", busy1, ovf1); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int bc;
    convert(27'd1000, bc);
    total++; if (bc !== 28) begin bad++; $display("FAIL busy_len got=%0d exp=28", bc); end
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL ovf_1000 got=%b exp=0", ovf1); end
    get_frame();
    exp = '{8'h03, 8'h03, 8'h03, 8'h9F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      total++; if (fr1[i] !== exp[i]) begin bad++; $display("FAIL d1000[%0d] got=%h exp=%h", i, fr1[i], exp[i]); end
    end
  endtask

  task automatic test_width();
    int bc;
    convert(27'd99_999_999, bc);
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL ovf_max8 got=%b exp=0", ovf1); end
    get_frame();
    for (int i = 0; i < 8; i++) begin
      total++; if (fr1[i] !== 8'b00001001) begin bad++; $display("FAIL d9s[%0d] got=%h exp=09", i, fr1[i]); end
    end
    convert(27'd100_000_000, bc);
    total++; if (ovf1 !== 1'b1 || ovf0 !== 1'b1) begin bad++; $display("FAIL ovf_1e8 got=%b/%b exp=1", ovf1, ovf0); end
    get_frame();
    for (int i = 0; i < 8; i++) begin
      total++; if (fr1[i] !== 8'hFD || fr0[i] !== 8'hFD) begin bad++; $display("FAIL dash[%0d] got=%h/%h exp=fd", i, fr1[i], fr0[i]); end
    end
  endtask

  task automatic test_zero();
    int bc;
    convert(27'd0, bc);
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL ovf_zero got=%b exp=0", ovf1); end
    get_frame();
    for (int i = 0; i < 8; i++) begin
      total++; if (fr0[i] !== 8'h03) begin bad++; $display("FAIL zero_noblank[%0d] got=%h exp=03", i, fr0[i]); end
      total++; if (fr1[i] !== ((i == 0) ? 8'h03 : 8'hFF)) begin bad++; $display("FAIL zero_blank[%0d] got=%h", i, fr1[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m;
    int bh = 0, late = 0, wbad = 0, nseen = 0;
    logic [7:0] seen = 8'h00;
    exp = '{8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'hFF, 8'hFF, 8'hFF};
    @(negedge clk);
    for (int c = 0; c < 100; c++) begin
      freq_valid = (c == 0 || c == 5 || c == 10);
      freq_value = (c == 0) ? 27'd12345 : (c == 5) ? 27'd500 : 27'd777;
      @(negedge clk);
      freq_valid = 1'b0;
      if (busy1) bh++;
      if (c >= 56 && busy1) late++;
      if (c >= 30 && c <= 55)
        for (int i = 0; i < 8; i++) begin
          m = ~(8'b1 << i);
          if (sel1 == m) begin
            seen[i] = 1'b1;
            if (seg1 !== exp[i]) wbad++;
          end
        end
    end
    for (int i = 0; i < 8; i++) nseen += int'(seen[i]);
    total++; if (bh !== 56) begin bad++; $display("FAIL b2b_busy got=%0d exp=56", bh); end
    total++; if (late !== 0) begin bad++; $display("FAIL b2b_third got=%0d exp=0", late); end
    total++; if (wbad !== 0 || nseen < 5) begin bad++; $display("FAIL b2b_first bad=%0d seen=%0d exp=0/>=5", wbad, nseen); end
    get_frame();
    exp = '{8'h1F, 8'h1F, 8'h1F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      total++; if (fr1[i] !== exp[i]) begin bad++; $display("FAIL b2b_777[%0d] got=%h exp=%h", i, fr1[i], exp[i]); end
    end
  endtask

  task automatic test_scan();
    int bc, sbad = 0, gbad = 0;
    logic [7:0] prev, m;
    bit found = 0;
    convert(27'd87_654_321, bc);
    exp = '{8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01};
    prev = sel1;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (sel1 == 8'hFE && prev != 8'hFE) found = 1;
      prev = sel1;
    end
    total++; if (!found) begin bad++; $display("FAIL scan_start got=none exp=fe"); end
    for (int j = 0; j < 32; j++) begin
      m = ~(8'b1 << (j / 4));
      if (sel1 !== m) sbad++;
      if (seg1 !== exp[j / 4]) gbad++;
      @(negedge clk);
    end
    total++; if (sbad !== 0) begin bad++; $display("FAIL scan_sel got=%0d wrong exp=0", sbad); end
    total++; if (gbad !== 0) begin bad++; $display("FAIL scan_seg got=%0d wrong exp=0", gbad); end
  endtask

  task automatic test_reset_abort();
    int bc;
    @(negedge clk);
    freq_value = 27'd54321; freq_valid = 1'b1;
    @(negedge clk);
    freq_valid = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy1); end
    total++; if (seg1 !== 8'h03 || sel1 !== 8'hFE) begin bad++; $display("FAIL abort_disp got=%h/%h exp=03/fe", seg1, sel1); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    get_frame();
    for (int i = 0; i < 8; i++) begin
      total++; if (fr1[i] !== ((i == 0) ? 8'h03 : 8'hFF)) begin bad++; $display("FAIL abort_frame[%0d] got=%h", i, fr1[i]); end
    end
    convert(27'd42, bc);
    total++; if (bc !== 28) begin bad++; $display("FAIL post_busy got=%0d exp=28", bc); end
    get_frame();
    exp = '{8'h25, 8'h99, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      total++; if (fr1[i] !== exp[i]) begin bad++; $display("FAIL d42[%0d] got=%h exp=%h", i, fr1[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width();
    test_zero();
    test_back_to_back();
    test_scan();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_bcd_display.md
Name: freq_bcd_display

Overview:
Downstream display stage of the frequency meter. It takes the 27-bit count latched once per second by the measurement block and converts it to 8 BCD digits, using a sequential shift-and-add-3 (double-dabble) converter. It then drives the 8-digit multiplexed seven-segment indicator with leading-zero blanking and an overflow indication. It replaces the time-of-day digit path, so the board shows the measured input frequency in Hz.

Parameters:
SCAN_DIV, 62500, clk cycles per digit slot (50 MHz / 62500 = 800 Hz digit rate, 100 Hz frame)
BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all 8 digits

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
freq_value  in  27  measured frequency in Hz, binary
freq_valid  in  1  one-cycle pulse; freq_value is valid in the same cycle
segments  out  8  active-low segments {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp
segments_bit  out  8  active-low digit select; bit0 = least-significant digit
busy  out  1  conversion in progress
overflow  out  1  the displayed value exceeds 99_999_999

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE; display register = 0; pending flag = 0.
  - Scan counter = 0; digit index = 0.
  - Outputs: segments_bit=8'b11111110, segments=8'b00000011 ("0"), busy=0, overflow=0.
- Reset mid-conversion aborts the conversion. Nothing partial reaches the display.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - On freq_valid, capture freq_value into the 27-bit shift register.
  - Clear the 36-bit BCD accumulator (9 digits).
  - Load bit count 27, go to CONV, set busy=1 at the same edge.
- CONV, once per clk:
  - First, every BCD nibble >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - Bit count decrements; after the 27th CONV cycle, go to DONE.
- DONE (one cycle):
  - Copy the low 8 BCD digits into the display register.
  - overflow = (9th BCD digit != 0).
  - busy=0 at that edge.
  - If the pending flag is set, start the pending value (next state CONV, busy stays high). Otherwise go to IDLE.
- Latency: freq_valid sampled at edge E0 → CONV at E1..E27 → display register and overflow update at E28.
  - busy is high from after E0 until after E28: 28 cycles.
- freq_valid while busy:
  - Store freq_value in a one-deep pending register and set the pending flag.
  - A later pulse overwrites the pending value; last value wins.
  - freq_valid in the DONE cycle also goes to pending.
- Width rules:
  - Maximum input is 134_217_727, which needs 9 BCD digits; the 9th digit is used only for overflow.
  - On overflow, every digit shows "-" (8'b11111101), with no blanking.
- Scan:
  - Free-running counter 0..SCAN_DIV-1; the digit index advances mod 8 when it wraps.
  - segments_bit = ~(1 << index).
  - segments and segments_bit are registered and change on the same edge. No glitch between the digit-select and segment outputs.
  - The scan is independent of conversion. The display register changes only in DONE, so a frame may mix old and new values for at most one frame.
- Decode per digit, active-low, dp always off (bit0=1):
  - 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001
  - 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001
  - Nibble values 10..15 cannot occur; decode them as blank (8'hFF).
- Blanking (BLANK_LZ=1):
  - A digit above the most significant non-zero digit outputs 8'hFF.
  - Digit 0 is always shown, so value 0 displays "0".

Test Plan:
1. Reset, then freq_valid with freq_value=1_000 → busy high exactly 28 cycles. Display digits 3..0 = "1000"; digits 7..4 segments=8'hFF; overflow=0.
2. freq_value=99_999_999 → all 8 digits 8'b00001001; overflow=0. Then freq_value=100_000_000 → every digit 8'b11111101; overflow=1.
3. freq_value=0 with BLANK_LZ=0 → all digits 8'b00000011. With BLANK_LZ=1 → only digit 0 lit as "0".
4. Pulse A=12_345 at E0, B=500 at E5, C=777 at E10 → display shows 12345 after E28. A second busy period follows back-to-back, then the display shows 777; B is never displayed.
5. SCAN_DIV=4 with display holding 87_654_321 → segments_bit steps FE,FD,FB,…,7F every 4 cycles. Segments match digit 1,2,…,8 on the same edge as the select.
6. Assert rst_n=0 at cycle 15 of a conversion of 54_321 → busy=0 and the display shows "0" immediately. After release, a new freq_valid of 42 converts normally, showing "42" at +28 cycles.
